// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : alu_seq_pkg                                                      |
// | Brief   : ALUCtr codes, ALUOp codes and FSM states for alu_op_sequencer.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package alu_seq_pkg;

  localparam logic [2:0] c_ALU_AND  = 3'b000;
  localparam logic [2:0] c_ALU_XOR  = 3'b001;
  localparam logic [2:0] c_ALU_SLL  = 3'b010;
  localparam logic [2:0] c_ALU_ADD  = 3'b011;
  localparam logic [2:0] c_ALU_SUB  = 3'b100;
  localparam logic [2:0] c_ALU_MUL  = 3'b101;
  localparam logic [2:0] c_ALU_ADDI = 3'b110;
  localparam logic [2:0] c_ALU_SRAI = 3'b111;

  localparam logic [1:0] c_ALUOP_BRANCH = 2'b00;
  localparam logic [1:0] c_ALUOP_LDST   = 2'b01;
  localparam logic [1:0] c_ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] c_ALUOP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : alu_op_sequencer_if                                            |
// | Brief     : Op-in / result-out handshake bundle of the ALU sequencer.      |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        ALUOp_i;
  logic [6:0]        funct7_i;
  logic [2:0]        funct3_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;
  logic [2:0]        ALUCtr_o;
  logic              busy_o;
  logic              illegal_o;

  modport master (
    output in_valid_i, ALUOp_i, funct7_i, funct3_i, data1_i, data2_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, ALUCtr_o, busy_o, illegal_o
  );

  modport slave (
    input  in_valid_i, ALUOp_i, funct7_i, funct3_i, data1_i, data2_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, ALUCtr_o, busy_o, illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/mul_iter_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mul_iter_unit                                                     |
// | Brief  : Iterative shift-add multiplier, one partial product per clock.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mul_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);
  localparam int              CNT_W      = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_acc_next;

  // product_o is the accumulator after the current step, valid when done_o
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign product_o  = w_acc_next;
  assign done_o     = (r_cnt == c_CNT_ONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (start_i) begin
      r_acc    <= '0;
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_cnt    <= c_CNT_LOAD;
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - c_CNT_ONE;
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_op_sequencer                                                  |
// | Brief  : Handshaked ALU issue controller; 1-cycle ops inline, MUL iterative|
// |          Option: ALU_SEQ_ILLEGAL_FLAG_EN enables the illegal_o flag.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_op_sequencer_if.slave    bus
);
  localparam int SHAMT_W = $clog2(DATA_W);

  state_t              r_state;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic [2:0]          r_ctr;
  logic [2:0]          w_ctr;
  logic                w_illegal;
  logic [DATA_W-1:0]   w_result;
  logic [SHAMT_W-1:0]  w_shamt;
  logic                w_accept;
  logic                w_mul_start;
  logic                w_mul_done;
  logic [DATA_W-1:0]   w_mul_product;

  assign w_accept    = bus.in_valid_i && (r_state == ST_IDLE);
  assign w_mul_start = w_accept && (w_ctr == c_ALU_MUL);
  assign w_shamt     = bus.data2_i[SHAMT_W-1:0];

  // Illegal codes fall through with ALUCtr = AND (000) and illegal raised
  always_comb begin
    w_ctr     = c_ALU_AND;
    w_illegal = 1'b0;
    case (bus.ALUOp_i)
      c_ALUOP_BRANCH: w_ctr = c_ALU_SUB;
      c_ALUOP_LDST:   w_ctr = c_ALU_ADD;
      c_ALUOP_RTYPE: begin
        case ({bus.funct7_i, bus.funct3_i})
          10'b0000000_111: w_ctr = c_ALU_AND;
          10'b0000000_100: w_ctr = c_ALU_XOR;
          10'b0000000_001: w_ctr = c_ALU_SLL;
          10'b0000000_000: w_ctr = c_ALU_ADD;
          10'b0100000_000: w_ctr = c_ALU_SUB;
          10'b0000001_000: w_ctr = c_ALU_MUL;
          default:         w_illegal = 1'b1;
        endcase
      end
      c_ALUOP_ITYPE: begin
        case (bus.funct3_i)
          3'b000:  w_ctr = c_ALU_ADDI;
          3'b101:  w_ctr = c_ALU_SRAI;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (w_ctr)
      c_ALU_AND:             w_result = bus.data1_i & bus.data2_i;
      c_ALU_XOR:             w_result = bus.data1_i ^ bus.data2_i;
      c_ALU_SLL:             w_result = bus.data1_i << w_shamt;
      c_ALU_ADD, c_ALU_ADDI: w_result = bus.data1_i + bus.data2_i;
      c_ALU_SUB:             w_result = bus.data1_i - bus.data2_i;
      c_ALU_SRAI:            w_result = $unsigned($signed(bus.data1_i) >>> w_shamt);
      default:               w_result = '0;
    endcase
    if (w_illegal) w_result = '0;
  end

  mul_iter_unit #(.DATA_W(DATA_W)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (w_mul_start),
    .a_i       (bus.data1_i),
    .b_i       (bus.data2_i),
    .done_o    (w_mul_done),
    .product_o (w_mul_product)
  );

`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
  logic r_illegal;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ctr    <= c_ALU_AND;
`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ctr <= w_ctr;
`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
            r_illegal <= w_illegal;
`endif
            if (w_mul_start) begin
              r_state <= ST_MUL;
            end else begin
              r_result <= w_result;
              r_zero   <= (w_result == '0);
              r_state  <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_result <= w_mul_product;
            r_zero   <= (w_mul_product == '0);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            r_state <= ST_IDLE;
`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
            r_illegal <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (r_state == ST_IDLE);
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign bus.out_valid_o = (r_state == ST_DONE);
  assign bus.result_o    = r_result;
  assign bus.zero_o      = r_zero;
  assign bus.ALUCtr_o    = r_ctr;
`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
  assign bus.illegal_o   = r_illegal;
`else
  assign bus.illegal_o   = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_alu_op_sequencer                                               |
// | Brief  : Directed self-checking bench for alu_op_sequencer (DATA_W = 32).  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_op_sequencer_if #(.DATA_W(32)) bus ();

  alu_op_sequencer #(.DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  ctr;
    logic [6:0]  lat;
  } vec_t;

  // Offers one op from an IDLE, post-edge point; lat counts edges from the
  // accept edge (counted as 1) until out_valid_o is seen.
  task automatic do_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic ready_seen);
    bus.ALUOp_i    = op;
    bus.funct7_i   = f7;
    bus.funct3_i   = f3;
    bus.data1_i    = a;
    bus.data2_i    = b;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat        = 1;
    ready_seen = 1'b0;
    while (!bus.out_valid_o && lat < 100) begin
      if (bus.in_ready_o) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_vec++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.result_o !== 32'h0 || bus.zero_o !== 1'b0 || bus.ALUCtr_o !== 3'b000 ||
        bus.illegal_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b res=%h z=%b ctr=%b ill=%b required rdy=1 others 0",
               bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.result_o, bus.zero_o,
               bus.ALUCtr_o, bus.illegal_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    vec_t vecs [10];
    int   lat;
    logic rs;
    vecs[0] = '{2'b10, 7'b0000000, 3'b000, 32'd5,        32'd7,        32'd12,       3'b011, 7'd1};
    vecs[1] = '{2'b10, 7'b0100000, 3'b000, 32'd3,        32'd5,        32'hFFFFFFFE, 3'b100, 7'd1};
    vecs[2] = '{2'b00, 7'b0000000, 3'b000, 32'd9,        32'd9,        32'h0,        3'b100, 7'd1};
    vecs[3] = '{2'b01, 7'b1111111, 3'b111, 32'h100,      32'h20,       32'h120,      3'b011, 7'd1};
    vecs[4] = '{2'b10, 7'b0000000, 3'b111, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 3'b000, 7'd1};
    vecs[5] = '{2'b10, 7'b0000000, 3'b100, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 3'b001, 7'd1};
    vecs[6] = '{2'b11, 7'b0000000, 3'b101, 32'h80000000, 32'd4,        32'hF8000000, 3'b111, 7'd1};
    vecs[7] = '{2'b10, 7'b0000000, 3'b001, 32'd1,        32'h21,       32'd2,        3'b010, 7'd1};
    vecs[8] = '{2'b11, 7'b0000000, 3'b000, 32'd10,       32'hFFFFFFFF, 32'd9,        3'b110, 7'd1};
    vecs[9] = '{2'b11, 7'b0100000, 3'b101, 32'h7FFFFFF0, 32'hFFFFFFE3, 32'h0FFFFFFE, 3'b111, 7'd1};
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b, lat, rs);
      n_vec++;
      if (bus.result_o !== vecs[i].res || bus.ALUCtr_o !== vecs[i].ctr ||
          bus.zero_o !== (vecs[i].res == 32'h0) || lat != int'(vecs[i].lat)) begin
        n_err++;
        $display("FAIL single_cycle[%0d]: got res=%h ctr=%b z=%b lat=%0d required res=%h ctr=%b z=%b lat=%0d",
                 i, bus.result_o, bus.ALUCtr_o, bus.zero_o, lat, vecs[i].res, vecs[i].ctr,
                 (vecs[i].res == 32'h0), vecs[i].lat);
      end
      release_result();
    end
  endtask

  task automatic test_mul();
    logic [31:0] a_tab [3];
    logic [31:0] b_tab [3];
    logic [31:0] p_tab [3];
    int   lat;
    logic rs;
    a_tab[0] = 32'hFFFFFFFF; b_tab[0] = 32'd3;        p_tab[0] = 32'hFFFFFFFD;
    a_tab[1] = 32'h00001234; b_tab[1] = 32'h10;       p_tab[1] = 32'h00012340;
    a_tab[2] = 32'h00010001; b_tab[2] = 32'h00010001; p_tab[2] = 32'h00020001;
    for (int i = 0; i < 3; i++) begin
      do_op(2'b10, 7'b0000001, 3'b000, a_tab[i], b_tab[i], lat, rs);
      n_vec++;
      if (bus.result_o !== p_tab[i] || bus.ALUCtr_o !== 3'b101 || lat != 33 || rs !== 1'b0) begin
        n_err++;
        $display("FAIL mul[%0d]: got res=%h ctr=%b lat=%0d ready_seen=%b required res=%h ctr=101 lat=33 ready_seen=0",
                 i, bus.result_o, bus.ALUCtr_o, lat, rs, p_tab[i]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic rs;
    do_op(2'b10, 7'b0000000, 3'b000, 32'd1, 32'd1, lat, rs);
    bus.ALUOp_i    = 2'b10;
    bus.funct3_i   = 3'b100;
    bus.data1_i    = 32'hDEADBEEF;
    bus.in_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.result_o !== 32'd2 ||
          bus.ALUCtr_o !== 3'b011 || bus.zero_o !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b res=%h ctr=%b z=%b required vld=1 rdy=0 res=00000002 ctr=011 z=0",
                 c, bus.out_valid_o, bus.in_ready_o, bus.result_o, bus.ALUCtr_o, bus.zero_o);
      end
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    n_vec++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.result_o !== 32'd2) begin
      n_err++;
      $display("FAIL release_to_idle: got vld=%b rdy=%b res=%h required vld=0 rdy=1 res=00000002",
               bus.out_valid_o, bus.in_ready_o, bus.result_o);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] f7_tab [2];
    logic [2:0] f3_tab [2];
    logic [1:0] op_tab [2];
    logic       exp_ill;
    int   lat;
    logic rs;
`ifdef ALU_SEQ_ILLEGAL_FLAG_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    op_tab[0] = 2'b10; f7_tab[0] = 7'b0100000; f3_tab[0] = 3'b111;
    op_tab[1] = 2'b11; f7_tab[1] = 7'b0000000; f3_tab[1] = 3'b001;
    for (int i = 0; i < 2; i++) begin
      do_op(op_tab[i], f7_tab[i], f3_tab[i], 32'h12345678, 32'h0F0F0F0F, lat, rs);
      n_vec++;
      if (bus.result_o !== 32'h0 || bus.zero_o !== 1'b1 || bus.ALUCtr_o !== 3'b000 ||
          bus.illegal_o !== exp_ill || lat != 1) begin
        n_err++;
        $display("FAIL illegal[%0d]: got res=%h z=%b ctr=%b ill=%b lat=%0d required res=0 z=1 ctr=000 ill=%b lat=1",
                 i, bus.result_o, bus.zero_o, bus.ALUCtr_o, bus.illegal_o, lat, exp_ill);
      end
      release_result();
      n_vec++;
      if (bus.illegal_o !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_clear[%0d]: got ill=%b required 0", i, bus.illegal_o);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen_valid;
    bus.ALUOp_i    = 2'b10;
    bus.funct7_i   = 7'b0000001;
    bus.funct3_i   = 3'b000;
    bus.data1_i    = 32'd7;
    bus.data2_i    = 32'd6;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL mul_busy_before_reset: got busy=%b required 1", bus.busy_o);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.result_o !== 32'h0 || bus.zero_o !== 1'b0 || bus.ALUCtr_o !== 3'b000 ||
        bus.illegal_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_mul: got rdy=%b vld=%b busy=%b res=%h z=%b ctr=%b ill=%b required rdy=1 others 0",
               bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.result_o, bus.zero_o,
               bus.ALUCtr_o, bus.illegal_o);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) seen_valid = 1'b1;
    end
    n_vec++;
    if (seen_valid !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL no_result_after_reset: got seen_valid=%b rdy=%b required seen_valid=0 rdy=1",
               seen_valid, bus.in_ready_o);
    end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.ALUOp_i     = 2'b00;
    bus.funct7_i    = 7'b0;
    bus.funct3_i    = 3'b0;
    bus.data1_i     = 32'h0;
    bus.data2_i     = 32'h0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
